// File: rtl/key_event_queue.sv
// Edge-detecting key event FIFO: synchronises the keypad valid/key pair and
// queues one event per press. Optional repeat filter: KEY_QUEUE_REPEAT_FILTER_EN.
module key_event_queue #(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 5000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_key,
  input  logic [3:0]               key,
  input  logic                     evt_ready,
  input  logic                     clear_overflow,
  output logic                     evt_valid,
  output logic [3:0]               evt_key,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_event_queue: DEPTH must be a power of two in 2..16");
  end
  if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 8388607) begin : g_bad_holdoff
    $error("key_event_queue: HOLDOFF_CYCLES must be in 1..2^23-1");
  end

  logic          v_s1_q, v_s2_q, v_s3_q;
  logic [3:0]    k_s1_q, k_s2_q;
  logic          rise_q, rise_d;
  logic          cand_vld_q;
  logic [3:0]    cand_key_q;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          evt_valid_q, evt_valid_d;
  logic [3:0]    evt_key_q, evt_key_d;
  logic          cand_ok_s;
  logic          pop_s, push_s, drop_s;

`ifdef KEY_QUEUE_REPEAT_FILTER_EN
  logic [22:0] hold_q, hold_d;
  logic [3:0]  last_key_q, last_key_d;

  // Repeat filter: a candidate matching the last accepted code inside the window vanishes.
  always_comb begin
    cand_ok_s  = cand_vld_q;
    last_key_d = last_key_q;
    if (hold_q != 23'd0) begin
      hold_d = hold_q - 23'd1;
    end else begin
      hold_d = hold_q;
    end
    if (cand_vld_q) begin
      if (cand_key_q == last_key_q && hold_q != 23'd0) begin
        cand_ok_s = 1'b0;
      end else begin
        last_key_d = cand_key_q;
        hold_d     = 23'(HOLDOFF_CYCLES - 1);
      end
    end else begin
      cand_ok_s = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q     <= 23'd0;
      last_key_q <= 4'd0;
    end else begin
      hold_q     <= hold_d;
      last_key_q <= last_key_d;
    end
  end
`else
  assign cand_ok_s = cand_vld_q;
`endif

  // Push/pop decision; a full queue still accepts when the head leaves this cycle.
  always_comb begin
    pop_s    = (count_q != CW'(0)) && evt_ready;
    push_s   = cand_ok_s && ((count_q != CW'(DEPTH)) || pop_s);
    drop_s   = cand_ok_s && !push_s;
    rise_d   = v_s2_q && !v_s3_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = cand_key_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new drop wins over a clear in the same cycle.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    evt_valid_d = (count_d != CW'(0));
    evt_key_d   = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_s1_q      <= 1'b1;
      v_s2_q      <= 1'b1;
      v_s3_q      <= 1'b1;
      k_s1_q      <= 4'd0;
      k_s2_q      <= 4'd0;
      rise_q      <= 1'b0;
      cand_vld_q  <= 1'b0;
      cand_key_q  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'd0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= 4'd0;
    end else begin
      v_s1_q      <= valid_key;
      v_s2_q      <= v_s1_q;
      v_s3_q      <= v_s2_q;
      k_s1_q      <= key;
      k_s2_q      <= k_s1_q;
      rise_q      <= rise_d;
      // Capture one cycle after the edge so the key bus has settled.
      cand_vld_q  <= rise_q;
      cand_key_q  <= k_s2_q;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: a queue-based reference model compared every cycle,
// plus directed presses with hand-computed expectations.
module tb_key_event_queue;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_key = 1'b0;
  logic [3:0] key = 4'd0;
  logic       evt_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       evt_valid;
  logic [3:0] evt_key;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  key_event_queue #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .valid_key(valid_key), .key(key),
    .evt_ready(evt_ready), .clear_overflow(clear_overflow),
    .evt_valid(evt_valid), .evt_key(evt_key), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: each sampled 0->1 of valid_key becomes a candidate 4 edges later.
  typedef struct { int due; logic [3:0] k; } pend_t;
  logic [3:0] mq[$];
  pend_t      pend[$];
  logic       m_ov;
  logic       prev_vk;
  int         cyc;
  logic [3:0] last_key;
  int         last_load;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      pend.delete();
      m_ov      = 1'b0;
      prev_vk   = 1'b1;
      cyc       = 0;
      last_key  = 4'd0;
      last_load = -1000000;
    end else begin
      bit         pop, cand;
      logic [3:0] ck;
      pend_t      p;
      cyc  = cyc + 1;
      pop  = (mq.size() > 0) && evt_ready;
      cand = 1'b0;
      ck   = 4'd0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        cand = 1'b1;
        ck   = pend[0].k;
        void'(pend.pop_front());
      end
      if (valid_key && !prev_vk) begin
        p.due = cyc + 4;
        p.k   = key;
        pend.push_back(p);
      end
      prev_vk = valid_key;
`ifdef KEY_QUEUE_REPEAT_FILTER_EN
      if (cand) begin
        if (ck == last_key && (cyc - last_load) < HOLD) begin
          cand = 1'b0;
        end else begin
          last_key  = ck;
          last_load = cyc;
        end
      end
`endif
      if (pop) void'(mq.pop_front());
      if (clear_overflow) m_ov = 1'b0;
      if (cand) begin
        if (mq.size() < DEPTH) mq.push_back(ck);
        else m_ov = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("model_evt_valid", int'(evt_valid), (mq.size() > 0) ? 1 : 0);
    cmp("model_count", int'(count), mq.size());
    cmp("model_overflow", int'(overflow), int'(m_ov));
    if (mq.size() > 0) cmp("model_evt_key", int'(evt_key), int'(mq[0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hi, input int lo);
    valid_key = 1'b1;
    key = code;
    repeat (hi) tick();
    valid_key = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic pop_expect(input string name, input logic [3:0] exp);
    cmp(name, int'(evt_key), int'(exp));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    evt_ready = 1'b0;
  endtask

  logic [3:0] six [6];
  logic [3:0] fill[4];
  int         base;

  initial begin
    six  = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8};
    fill = '{4'd3, 4'd7, 4'd11, 4'd13};
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    cmp("reset_evt_valid", int'(evt_valid), 0);
    cmp("reset_evt_key", int'(evt_key), 0);
    cmp("reset_count", int'(count), 0);
    cmp("reset_overflow", int'(overflow), 0);
    repeat (4) tick();

    // Latency: first high sample at edge 0, visible right after edge 4.
    valid_key = 1'b1;
    key = 4'b0110;
    repeat (4) tick();
    cmp("latency_early", int'(evt_valid), 0);
    tick();
    cmp("latency_valid", int'(evt_valid), 1);
    cmp("latency_key", int'(evt_key), 6);
    cmp("latency_count", int'(count), 1);
    repeat (5) tick();
    valid_key = 1'b0;
    repeat (4) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    cmp("pop_count", int'(count), 0);
    cmp("pop_valid", int'(evt_valid), 0);

    // Long hold yields a single event.
    valid_key = 1'b1;
    key = 4'b0101;
    repeat (200) tick();
    valid_key = 1'b0;
    repeat (4) tick();
    cmp("hold_count", int'(count), 1);
    cmp("hold_key", int'(evt_key), 5);
    drain();

    // Six presses into a 4-deep queue.
    foreach (six[i]) press(six[i], 4, 4);
    repeat (4) tick();
    cmp("full_count", int'(count), 4);
    cmp("full_overflow", int'(overflow), 1);
    for (int i = 0; i < 4; i++) pop_expect("full_order", six[i]);
    cmp("full_empty", int'(count), 0);
    cmp("ovf_still_set", int'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    cmp("ovf_cleared", int'(overflow), 0);

    // Full queue: candidate arrives in the same cycle as a pop.
    foreach (fill[i]) press(fill[i], 4, 4);
    repeat (4) tick();
    cmp("fill_count", int'(count), 4);
    valid_key = 1'b1;
    key = 4'd14;
    repeat (4) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    cmp("swap_count", int'(count), 4);
    cmp("swap_overflow", int'(overflow), 0);
    repeat (3) tick();
    valid_key = 1'b0;
    repeat (4) tick();
    pop_expect("swap_order0", 4'd7);
    pop_expect("swap_order1", 4'd11);
    pop_expect("swap_order2", 4'd13);
    pop_expect("swap_order3", 4'd14);

    // Asynchronous reset with three queued entries and valid_key held high.
    press(4'd1, 4, 4);
    press(4'd2, 4, 4);
    press(4'd3, 4, 4);
    repeat (4) tick();
    cmp("pre_reset_count", int'(count), 3);
    valid_key = 1'b1;
    key = 4'd12;
    #2 reset = 1'b0;
    #1;
    cmp("async_evt_valid", int'(evt_valid), 0);
    cmp("async_evt_key", int'(evt_key), 0);
    cmp("async_count", int'(count), 0);
    cmp("async_overflow", int'(overflow), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    repeat (20) tick();
    cmp("no_event_held_high", int'(count), 0);
    valid_key = 1'b0;
    repeat (4) tick();
    press(4'd12, 8, 4);
    cmp("event_after_toggle", int'(count), 1);
    cmp("event_after_key", int'(evt_key), 12);
    drain();

    // Repeat presses of 9 close together, later, and a different code.
    press(4'd9, 3, 3);
    press(4'd9, 3, 3);
    repeat (4) tick();
`ifdef KEY_QUEUE_REPEAT_FILTER_EN
    base = 1;
`else
    base = 2;
`endif
    cmp("repeat_close", int'(count), base);
    repeat (20) tick();
    press(4'd9, 3, 3);
    repeat (4) tick();
    cmp("repeat_late", int'(count), base + 1);
    press(4'd10, 3, 3);
    repeat (4) tick();
    cmp("repeat_other", int'(count), base + 2);
    cmp("repeat_head", int'(evt_key), 9);
    drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
